// File: rtl/stepper_pkg.sv
// stepper_pkg: shared types and constants for the microstepping stepper driver.
//   step_mode_e : step sequencing mode as presented on the step_mode input
//   state_e     : driver state (DISABLED / RUN / HOLD)
//   coil_e      : signed coil polarity
//   PHASE_TABLE : 8-entry phase index -> (coil A, coil B) polarity table
//   coil_drive  : polarity -> {IN1, IN2} H-bridge encoding
package stepper_pkg;

  typedef enum logic [1:0] {
    MODE_FULL     = 2'b00,
    MODE_HALF     = 2'b01,
    MODE_WAVE     = 2'b10,
    MODE_HALF_ALT = 2'b11
  } step_mode_e;

  typedef enum logic [1:0] {
    ST_DISABLED = 2'd0,
    ST_RUN      = 2'd1,
    ST_HOLD     = 2'd2
  } state_e;

  typedef enum logic [1:0] {
    COIL_ZERO = 2'd0,
    COIL_POS  = 2'd1,
    COIL_NEG  = 2'd2
  } coil_e;

  typedef struct packed {
    coil_e a;
    coil_e b;
  } phase_t;

  // Half-step electrical cycle. Odd indices energise both coils (full-step
  // positions), even indices energise one coil (wave positions).
  localparam phase_t PHASE_TABLE [0:7] = '{
    '{a: COIL_ZERO, b: COIL_NEG },
    '{a: COIL_POS,  b: COIL_NEG },
    '{a: COIL_POS,  b: COIL_ZERO},
    '{a: COIL_POS,  b: COIL_POS },
    '{a: COIL_ZERO, b: COIL_POS },
    '{a: COIL_NEG,  b: COIL_POS },
    '{a: COIL_NEG,  b: COIL_ZERO},
    '{a: COIL_NEG,  b: COIL_NEG }
  };

  // Returns {IN1, IN2}: + drives IN1, - drives IN2, 0 leaves both low.
  function automatic logic [1:0] coil_drive(input coil_e c);
    logic [1:0] r;
    r = 2'b00;
    case (c)
      COIL_POS: r = 2'b10;
      COIL_NEG: r = 2'b01;
      default:  r = 2'b00;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/vref_pwm_gen.sv
// vref_pwm_gen: free-running PWM for the bridge current reference.
//   clk, rst : clock and synchronous active-high reset
//   level    : duty in counts out of 2^PWM_W (0 = constantly low)
//   pwm      : registered, high while counter < level
module vref_pwm_gen #(
  parameter int PWM_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [PWM_W-1:0] level,
  output logic             pwm
);

  logic [PWM_W-1:0] cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
      pwm <= 1'b0;
    end else begin
      cnt <= cnt + PWM_W'(1);
      pwm <= (cnt < level);
    end
  end

endmodule

// File: rtl/stepper_microstep.sv
// stepper_microstep: two-coil bipolar stepper driver with full / half / wave
// sequencing, run/hold current reduction and an optional position counter.
//   clk, rst              : clock, synchronous active-high reset
//   rotate_pulse          : asynchronous step request (rising edge = one step)
//   direction             : 1 forward (index +), 0 reverse
//   module_enable         : driver enable
//   step_mode             : 00 full, 01 half, 10 wave, 11 half
//   vref_level/hold_level : run / hold current duty
//   INA1..INB2            : registered H-bridge inputs
//   STANBY                : bridge standby (low = sleep)
//   VREF_PWM              : current reference PWM
//   position              : signed half-step position (0 unless STEPPER_POSITION_EN)
//   step_ack              : one-cycle pulse per accepted step
//   state_dbg             : current driver state
// Optional feature macro: STEPPER_POSITION_EN enables the position counter.
//
// Handshake: rotate_pulse carries no ready; each synchronised rising edge seen
// while enabled is accepted unconditionally and reported by step_ack in the
// same cycle the coil outputs change.
import stepper_pkg::*;

module stepper_microstep #(
  parameter int PWM_W       = 8,
  parameter int POS_W       = 16,
  parameter int HOLD_CYCLES = 1_000_000
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             rotate_pulse,
  input  logic             direction,
  input  logic             module_enable,
  input  logic [1:0]       step_mode,
  input  logic [PWM_W-1:0] vref_level,
  input  logic [PWM_W-1:0] hold_level,
  output logic             INA1,
  output logic             INA2,
  output logic             INB1,
  output logic             INB2,
  output logic             STANBY,
  output logic             VREF_PWM,
  output logic [POS_W-1:0] position,
  output logic             step_ack,
  output state_e           state_dbg
);

  localparam int IDLE_W = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;

  // Two synchroniser flops plus one history flop for edge detection.
  logic sync1, sync2, sync3;
  logic step_edge, step_accept;

  state_e           state_q, state_d;
  logic [IDLE_W-1:0] idle_q, idle_d;
  logic [2:0]       idx_q, idx_d, idx_step;
  logic [2:0]       mag;
  step_mode_e       mode;
  logic [PWM_W-1:0] level_sel;
  logic [3:0]       drive_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
      sync3 <= 1'b0;
    end else begin
      sync1 <= rotate_pulse;
      sync2 <= sync1;
      sync3 <= sync2;
    end
  end

  assign step_edge   = sync2 & ~sync3;
  assign step_accept = step_edge & module_enable & (state_q != ST_DISABLED);

  // Full mode lives on odd indices, wave on even; a step from the wrong
  // parity moves by one to realign, otherwise by two.
  always_comb begin
    mode = step_mode_e'(step_mode);
    mag  = 3'd1;
    case (mode)
      MODE_FULL: mag = idx_q[0]  ? 3'd2 : 3'd1;
      MODE_WAVE: mag = !idx_q[0] ? 3'd2 : 3'd1;
      default:   mag = 3'd1;
    endcase
    idx_step = direction ? (idx_q + mag) : (idx_q - mag);
  end

  always_comb begin
    state_d = state_q;
    idle_d  = idle_q;
    if (!module_enable) begin
      state_d = ST_DISABLED;
      idle_d  = '0;
    end else begin
      case (state_q)
        ST_DISABLED: begin
          state_d = ST_RUN;
          idle_d  = '0;
        end
        ST_RUN: begin
          if (step_accept) begin
            idle_d = '0;
          end else if (idle_q == IDLE_W'(HOLD_CYCLES - 1)) begin
            state_d = ST_HOLD;
            idle_d  = '0;
          end else begin
            idle_d = idle_q + IDLE_W'(1);
          end
        end
        ST_HOLD: begin
          idle_d = '0;
          if (step_accept) state_d = ST_RUN;
        end
        default: begin
          state_d = ST_DISABLED;
          idle_d  = '0;
        end
      endcase
    end
  end

  always_comb begin
    idx_d   = step_accept ? idx_step : idx_q;
    drive_d = 4'b0000;
    if (state_d != ST_DISABLED) begin
      drive_d = {coil_drive(PHASE_TABLE[idx_d].a), coil_drive(PHASE_TABLE[idx_d].b)};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_DISABLED;
      idle_q   <= '0;
      idx_q    <= 3'd0;
      INA1     <= 1'b0;
      INA2     <= 1'b0;
      INB1     <= 1'b0;
      INB2     <= 1'b0;
      STANBY   <= 1'b0;
      step_ack <= 1'b0;
    end else begin
      state_q  <= state_d;
      idle_q   <= idle_d;
      idx_q    <= idx_d;
      {INA1, INA2, INB1, INB2} <= drive_d;
      STANBY   <= (state_d != ST_DISABLED);
      step_ack <= step_accept;
    end
  end

  assign state_dbg = state_q;

  always_comb begin
    level_sel = '0;
    case (state_q)
      ST_RUN:  level_sel = vref_level;
      ST_HOLD: level_sel = hold_level;
      default: level_sel = '0;
    endcase
  end

  vref_pwm_gen #(.PWM_W(PWM_W)) u_vref_pwm (
    .clk   (clk),
    .rst   (rst),
    .level (level_sel),
    .pwm   (VREF_PWM)
  );

`ifdef STEPPER_POSITION_EN
  logic [POS_W-1:0] pos_q;
  logic [POS_W-1:0] pos_delta;

  // Same signed move as the phase index, in half-step units.
  assign pos_delta = direction ? POS_W'(mag) : (POS_W'(0) - POS_W'(mag));

  always_ff @(posedge clk) begin
    if (rst) begin
      pos_q <= '0;
    end else if (step_accept) begin
      pos_q <= pos_q + pos_delta;
    end
  end

  assign position = pos_q;
`else
  assign position = '0;
`endif

endmodule
